// File: rtl/game_pkg.sv
// Shared encodings and constants for the breakout game datapath.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_COUNT = 3'd2,
        ST_PLAY  = 3'd3,
        ST_MISS  = 3'd4,
        ST_WIN   = 3'd5,
        ST_LOSE  = 3'd6
    } state_e;

    // Ball step per tick at each speed level
    localparam logic [1:0] SPEED_L1 = 2'd1;
    localparam logic [1:0] SPEED_L2 = 2'd2;
    localparam logic [1:0] SPEED_L3 = 2'd3;

    // 12-bit RGB colours shared by the ball and brick renderers
    localparam logic [11:0] COL_BG     = 12'h000;
    localparam logic [11:0] COL_WALL   = 12'hFFF;
    localparam logic [11:0] COL_BALL   = 12'hFF0;
    localparam logic [11:0] COL_PADDLE = 12'h0FF;
    localparam logic [11:0] COL_WIN    = 12'h0F0;
    localparam logic [11:0] COL_LOSE   = 12'hF00;

    // Playfield boundaries in pixels
    localparam int unsigned WALL_L_X = 8;
    localparam int unsigned WALL_R_X = 631;
    localparam int unsigned WALL_T_Y = 8;
    localparam int unsigned FLOOR_Y  = 470;

    // Speed level from the score tens digit
    function automatic logic [1:0] level_of(input logic [3:0] tens, input int l2, input int l3);
        if ({28'd0, tens} >= l3)      return SPEED_L3;
        else if ({28'd0, tens} >= l2) return SPEED_L2;
        else                          return SPEED_L1;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score: increments on inc, saturates at 99, sync clear.
module bcd_score_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens
);
    logic [3:0] ones_q, ones_d, tens_q, tens_d;

    // Next score: clear wins, then a non-saturated increment with ones carry
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Score registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;
endmodule

// File: rtl/game_sequencer.sv
// Game-flow FSM: serve/countdown/play/miss/win/lose, lives and countdown.
module game_sequencer
    import game_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int SERVE_TICKS = 30,
    parameter int L2_TENS     = 2,
    parameter int L3_TENS     = 4,
    parameter int WIN_TENS    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       brick_hit,
    input  logic       ball_miss,
    input  logic       grid_empty,
    output logic       serve,
    output logic       clear_grid,
    output logic       run,
    output logic [1:0] speed,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] lives,
    output logic [2:0] game_state
);
    state_e     state_q, state_d;
    logic       start_q;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] lives_q, lives_d;
    logic       serve_q, serve_d, clear_q, clear_d;
    logic       score_clr, score_inc;
    logic       press, win_now;

    // A held button counts as a single press
    assign press   = start & ~start_q;
    assign win_now = ({28'd0, score_tens} >= WIN_TENS) || grid_empty;

    bcd_score_counter u_score (
        .clk  (clk),
        .rst  (rst),
        .clr  (score_clr),
        .inc  (score_inc),
        .ones (score_ones),
        .tens (score_tens)
    );

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            cnt_q   <= 8'd0;
            lives_q <= 4'(START_LIVES);
            serve_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            cnt_q   <= cnt_d;
            lives_q <= lives_d;
            serve_q <= serve_d;
            clear_q <= clear_d;
        end
    end

    // Next-state: win outranks a same-cycle miss
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (press) state_d = ST_SERVE;
            ST_SERVE: if (press) state_d = ST_COUNT;
            ST_COUNT: if (tick && cnt_q == 8'd1) state_d = ST_PLAY;
            ST_PLAY: begin
                if (win_now)        state_d = ST_WIN;
                else if (ball_miss) state_d = ST_MISS;
            end
            ST_MISS:  state_d = (lives_q > 4'd1) ? ST_SERVE : ST_LOSE;
            ST_WIN, ST_LOSE: if (press) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath updates; serve/clear are registered one-cycle pulses
    always_comb begin
        cnt_d     = cnt_q;
        lives_d   = lives_q;
        serve_d   = 1'b0;
        clear_d   = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;
        case (state_q)
            ST_IDLE: if (press) begin
                score_clr = 1'b1;
                lives_d   = 4'(START_LIVES);
                serve_d   = 1'b1;
                clear_d   = 1'b1;
            end
            ST_SERVE: if (press) cnt_d = 8'(SERVE_TICKS);
            ST_COUNT: if (tick) cnt_d = cnt_q - 8'd1;
            ST_PLAY:  score_inc = brick_hit;
            ST_MISS: begin
                if (lives_q > 4'd1) begin
                    lives_d = lives_q - 4'd1;
                    serve_d = 1'b1;
                end else begin
                    lives_d = 4'd0;
                end
            end
            default: ;
        endcase
        run   = (state_q == ST_PLAY);
        speed = run ? level_of(score_tens, L2_TENS, L3_TENS) : 2'd0;
    end

    assign serve      = serve_q;
    assign clear_grid = clear_q;
    assign lives      = lives_q;
    assign game_state = state_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; a second instance with an unreachable
// win threshold exercises score saturation at 99.
module tb_game_sequencer;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, start = 1'b0;
    logic brick_hit = 1'b0, ball_miss = 1'b0, grid_empty = 1'b0;

    logic       serve, clear_grid, run;
    logic [1:0] speed;
    logic [3:0] ones, tens, lives;
    logic [2:0] gs;

    logic       b_serve, b_clear, b_run;
    logic [1:0] b_speed;
    logic [3:0] b_ones, b_tens, b_lives;
    logic [2:0] b_gs;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    game_sequencer u_dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .brick_hit(brick_hit), .ball_miss(ball_miss), .grid_empty(grid_empty),
        .serve(serve), .clear_grid(clear_grid), .run(run), .speed(speed),
        .score_ones(ones), .score_tens(tens), .lives(lives), .game_state(gs)
    );

    game_sequencer #(.WIN_TENS(10)) u_dut99 (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .brick_hit(brick_hit), .ball_miss(ball_miss), .grid_empty(grid_empty),
        .serve(b_serve), .clear_grid(b_clear), .run(b_run), .speed(b_speed),
        .score_ones(b_ones), .score_tens(b_tens), .lives(b_lives), .game_state(b_gs)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input state_e exp);
        chk(tag, {5'd0, gs}, {5'd0, exp});
    endtask

    task automatic press();
        start = 1'b1; cyc();
        start = 1'b0; cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic hits(input int n);
        brick_hit = 1'b1;
        repeat (n) cyc();
        brick_hit = 1'b0;
    endtask

    task automatic to_play();
        press();
        ticks(30);
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        rst = 1'b0; cyc();
        chk_st("rst_state", ST_IDLE);
        chk("rst_score", {tens, ones}, 8'h00);
        chk("rst_lives", {4'd0, lives}, 8'd3);
        chk("rst_speed", {6'd0, speed}, 8'd0);
        chk("rst_run", {7'd0, run}, 8'd0);
        chk("rst_serve", {7'd0, serve}, 8'd0);
        chk("rst_clear", {7'd0, clear_grid}, 8'd0);

        // New game: serve and clear pulse for exactly one cycle
        start = 1'b1; cyc();
        chk_st("new_state", ST_SERVE);
        chk("new_serve", {7'd0, serve}, 8'd1);
        chk("new_clear", {7'd0, clear_grid}, 8'd1);
        chk("new_lives", {4'd0, lives}, 8'd3);
        chk("new_speed", {6'd0, speed}, 8'd0);
        start = 1'b0; cyc();
        chk("serve_1cyc", {7'd0, serve}, 8'd0);
        chk("clear_1cyc", {7'd0, clear_grid}, 8'd0);

        // Hits in SERVE are ignored
        hits(3); cyc();
        chk("serve_hits", {tens, ones}, 8'h00);

        // Countdown, with an ignored press part-way
        press();
        chk_st("count_state", ST_COUNT);
        ticks(10);
        press();
        chk_st("count_press", ST_COUNT);
        ticks(19);
        chk_st("count_29", ST_COUNT);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk_st("play_state", ST_PLAY);
        chk("play_run", {7'd0, run}, 8'd1);
        chk("play_speed", {6'd0, speed}, 8'd1);

        // Hit and miss together at 09
        hits(9);
        chk("score_09", {tens, ones}, 8'h09);
        brick_hit = 1'b1; ball_miss = 1'b1; cyc();
        brick_hit = 1'b0; ball_miss = 1'b0;
        chk_st("hm_miss", ST_MISS);
        chk("hm_score", {tens, ones}, 8'h10);
        cyc();
        chk_st("hm_serve_st", ST_SERVE);
        chk("hm_serve", {7'd0, serve}, 8'd1);
        chk("hm_lives", {4'd0, lives}, 8'd2);

        // Speed levels and win by score
        to_play();
        hits(9);
        chk("score_19", {tens, ones}, 8'h19);
        chk("speed_19", {6'd0, speed}, 8'd1);
        hits(1);
        chk("score_20", {tens, ones}, 8'h20);
        chk("speed_20", {6'd0, speed}, 8'd2);
        hits(19);
        chk("speed_39", {6'd0, speed}, 8'd2);
        hits(1);
        chk("speed_40", {6'd0, speed}, 8'd3);
        hits(20);
        chk("score_60", {tens, ones}, 8'h60);
        chk_st("play_60", ST_PLAY);
        cyc();
        chk_st("win_state", ST_WIN);
        chk("win_run", {7'd0, run}, 8'd0);
        chk("win_speed", {6'd0, speed}, 8'd0);
        hits(2); cyc();
        chk("win_frozen", {tens, ones}, 8'h60);

        // Back to IDLE, then a fresh game
        press();
        chk_st("win_idle", ST_IDLE);
        start = 1'b1; cyc();
        chk("g2_clear", {7'd0, clear_grid}, 8'd1);
        chk("g2_score", {tens, ones}, 8'h00);
        chk("g2_lives", {4'd0, lives}, 8'd3);
        start = 1'b0; cyc();
        ball_miss = 1'b1; cyc(); ball_miss = 1'b0; cyc();
        chk("serve_miss", {4'd0, lives}, 8'd3);
        chk_st("serve_miss_st", ST_SERVE);

        // Three misses end in LOSE
        for (int k = 0; k < 3; k++) begin
            to_play();
            ball_miss = 1'b1; cyc(); ball_miss = 1'b0;
            chk_st("miss_st", ST_MISS);
            cyc();
            if (k < 2) begin
                chk_st("reserve_st", ST_SERVE);
                chk("reserve_pulse", {7'd0, serve}, 8'd1);
                chk("reserve_lives", {4'd0, lives}, 8'(2 - k));
            end else begin
                chk_st("lose_st", ST_LOSE);
                chk("lose_lives", {4'd0, lives}, 8'd0);
                chk("lose_serve", {7'd0, serve}, 8'd0);
            end
        end

        // grid_empty wins over a same-cycle miss
        press();
        press();
        to_play();
        grid_empty = 1'b1; ball_miss = 1'b1; cyc();
        grid_empty = 1'b0; ball_miss = 1'b0;
        chk_st("ge_win", ST_WIN);
        chk("ge_lives", {4'd0, lives}, 8'd3);

        // Reset in the middle of a countdown
        press();
        press();
        press();
        ticks(5);
        chk_st("pre_rst", ST_COUNT);
        rst = 1'b1; cyc();
        chk_st("mid_rst_st", ST_IDLE);
        chk("mid_rst_lives", {4'd0, lives}, 8'd3);
        chk("mid_rst_score", {tens, ones}, 8'h00);
        chk("mid_rst_serve", {7'd0, serve}, 8'd0);
        chk("mid_rst_clear", {7'd0, clear_grid}, 8'd0);
        chk("mid_rst_speed", {6'd0, speed}, 8'd0);
        rst = 1'b0; cyc();

        // Saturation at 99 on the no-win instance
        press();
        to_play();
        hits(99);
        chk("sat_99", {b_tens, b_ones}, 8'h99);
        chk("sat_speed", {6'd0, b_speed}, 8'd3);
        hits(1);
        chk("sat_hold", {b_tens, b_ones}, 8'h99);
        chk("sat_state", {5'd0, b_gs}, {5'd0, ST_PLAY});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
